ft245_sync_fifo: RTL and testbench



---
 rtl/ft245_sync_fifo_pkg.sv | 17 +
 rtl/ft245_sync_fifo_if.sv | 26 ++
 rtl/ft245_sync_fifo_fwft.sv | 61 ++++++
 rtl/ft245_sync_fifo.sv | 160 ++++++++++++++++
 tb/tb_ft245_sync_fifo.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_sync_fifo_pkg.sv
// Shared types and constants for the FT245 synchronous FIFO bridge.
package ft245_pkg;

    localparam int unsigned BYTE_W = 8;

    // Inactive level of the active-low chip strobes.
    localparam logic STROBE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRdOe,
        StRd,
        StRdEnd,
        StWr
    } state_e;

endpackage

// File: rtl/ft245_sync_fifo_if.sv
// Host-side byte stream interface of the FT245 bridge (RX pop side, TX push side).
interface ft245_sync_fifo_if;
    import ft245_pkg::*;

    logic              in_fifo_rst;
    logic              in_fifo_rd;
    logic              in_fifo_empty;
    logic [BYTE_W-1:0] in_fifo_data;
    logic              sof;
    logic              out_fifo_wr;
    logic              out_fifo_full;
    logic [BYTE_W-1:0] out_fifo_data;

    // Host logic side.
    modport master (
        output in_fifo_rst, in_fifo_rd, out_fifo_wr, out_fifo_data,
        input  in_fifo_empty, in_fifo_data, sof, out_fifo_full
    );

    // Bridge side.
    modport slave (
        input  in_fifo_rst, in_fifo_rd, out_fifo_wr, out_fifo_data,
        output in_fifo_empty, in_fifo_data, sof, out_fifo_full
    );

endinterface

// File: rtl/ft245_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Overflowing pushes and
// underflowing pops are ignored; the head reads as zero while empty.
module sync_fifo_fwft #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers; flush empties the FIFO like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ft245_sync_fifo.sv
// FT245 synchronous-FIFO PHY bridge: RX/TX byte buffers plus the bus
// arbitration FSM that drives OE#/RD#/WR# and the shared data bus.
module ft245_sync_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned RX_AW     = 9,
    parameter int unsigned TX_AW     = 9,
    parameter int unsigned RX_MARGIN = 4
) (
    input  logic                clk,
    input  logic                rst,
    ft245_sync_fifo_if.slave    host,
    input  logic                ftdi_clk,
    inout  wire  [BYTE_W-1:0]   ftdi_data,
    input  logic                ftdi_txe_n,
    output logic                ftdi_wr_n,
    input  logic                ftdi_rde_n,
    output logic                ftdi_rd_n,
    output logic                ftdi_oe_n,
    output logic                ftdi_siwu,
    input  logic                ftdi_suspend_n
);

    localparam logic [RX_AW:0] RX_DEPTH_W  = (RX_AW+1)'(2**RX_AW);
    localparam logic [RX_AW:0] RX_MARGIN_W = (RX_AW+1)'(RX_MARGIN);

    state_e state_q, state_d;
    logic   rd_n_q, rd_n_d, oe_n_q, oe_n_d, wr_n_q, wr_n_d;
    logic   rx_empty_prev_q;

    logic              rx_push, rx_full, rx_empty, rx_room;
    logic [RX_AW:0]    rx_count, rx_free;
    logic [BYTE_W-1:0] rx_head;
    logic              tx_pop, tx_full, tx_empty, tx_more;
    logic [TX_AW:0]    tx_count, tx_left;
    logic [BYTE_W-1:0] tx_head;
    logic              data_oe;
    logic              unused_sig;

    // A byte moves on every edge where the registered strobe and the chip flag are both low.
    assign rx_push = !rd_n_q && !ftdi_rde_n;
    assign tx_pop  = !wr_n_q && !ftdi_txe_n;
    assign rx_free = RX_DEPTH_W - rx_count;
    assign rx_room = (rx_free >= RX_MARGIN_W);
    assign tx_left = tx_count - (TX_AW+1)'(tx_pop);
    assign tx_more = (tx_left != '0);

    sync_fifo_fwft #(.DW(BYTE_W), .AW(RX_AW)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (host.in_fifo_rst),
        .push      (rx_push),
        .push_data (ftdi_data),
        .pop       (host.in_fifo_rd),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo_fwft #(.DW(BYTE_W), .AW(TX_AW)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (host.out_fifo_wr),
        .push_data (host.out_fifo_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // Bus is only driven in WR; entry to WR always passes through IDLE, so
    // there is at least one undriven cycle after OE# was low.
    assign data_oe   = (state_q == StWr);
    assign ftdi_data = data_oe ? tx_head : 8'hzz;

    assign ftdi_rd_n = rd_n_q;
    assign ftdi_oe_n = oe_n_q;
    assign ftdi_wr_n = wr_n_q;
    assign ftdi_siwu = STROBE_IDLE;

    assign host.in_fifo_empty = rx_empty;
    assign host.in_fifo_data  = rx_head;
    assign host.out_fifo_full = tx_full;
    assign host.sof           = rx_empty_prev_q && !rx_empty;

    assign unused_sig = ^{ftdi_clk, rx_full};

    // Next state and next strobe levels; strobes are registered with the state.
    always_comb begin
        state_d = state_q;
        rd_n_d  = STROBE_IDLE;
        oe_n_d  = STROBE_IDLE;
        wr_n_d  = STROBE_IDLE;
        unique case (state_q)
            StIdle: begin
                if (!ftdi_suspend_n) begin
                    state_d = StIdle;
                end else if (!ftdi_rde_n && rx_room) begin
                    state_d = StRdOe;
                    oe_n_d  = 1'b0;
                end else if (!ftdi_txe_n && !tx_empty) begin
                    state_d = StWr;
                    wr_n_d  = 1'b0;
                end
            end
            StRdOe: begin
                state_d = StRd;
                oe_n_d  = 1'b0;
                rd_n_d  = 1'b0;
            end
            StRd: begin
                oe_n_d = 1'b0;
                if (ftdi_rde_n || !rx_room || !ftdi_suspend_n) begin
                    state_d = StRdEnd;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            StRdEnd: begin
                state_d = StIdle;
            end
            StWr: begin
                if (!tx_more || ftdi_txe_n || !ftdi_suspend_n || (!ftdi_rde_n && rx_room)) begin
                    state_d = StIdle;
                end else begin
                    wr_n_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rd_n_q  <= STROBE_IDLE;
            oe_n_q  <= STROBE_IDLE;
            wr_n_q  <= STROBE_IDLE;
        end else begin
            state_q <= state_d;
            rd_n_q  <= rd_n_d;
            oe_n_q  <= oe_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    // Previous RX empty flag; sof marks the first cycle a new head byte is visible.
    always_ff @(posedge clk) begin
        if (rst || host.in_fifo_rst) begin
            rx_empty_prev_q <= 1'b1;
        end else begin
            rx_empty_prev_q <= rx_empty;
        end
    end

endmodule

// File: tb/tb_ft245_sync_fifo.sv
// Directed bench for ft245_sync_fifo with a small FT245 chip model.
module tb_ft245_sync_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ft245_sync_fifo_if hif ();

    wire  [7:0] ftdi_data;
    logic       txe_n, suspend_n;
    logic       rde_n;
    logic       wr_n, rd_n, oe_n, siwu;

    ft245_sync_fifo #(.RX_AW(3), .TX_AW(3), .RX_MARGIN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .host           (hif),
        .ftdi_clk       (clk),
        .ftdi_data      (ftdi_data),
        .ftdi_txe_n     (txe_n),
        .ftdi_wr_n      (wr_n),
        .ftdi_rde_n     (rde_n),
        .ftdi_rd_n      (rd_n),
        .ftdi_oe_n      (oe_n),
        .ftdi_siwu      (siwu),
        .ftdi_suspend_n (suspend_n)
    );

    // Chip model: a byte list, advanced on each accepted read edge.
    logic [7:0] chip_mem [64];
    int         chip_len = 0;
    int         chip_idx = 0;
    logic [7:0] chip_byte;
    assign rde_n     = (chip_idx >= chip_len);
    assign chip_byte = chip_mem[chip_idx[5:0]];
    assign ftdi_data = !oe_n ? chip_byte : 8'hzz;

    always @(posedge clk) begin
        if (!rst && !rd_n && !rde_n) chip_idx <= chip_idx + 1;
    end

    // Chip-side capture of written bytes.
    logic [7:0] tx_log [64];
    int         tx_cnt = 0;
    int         wr_low = 0;
    always @(posedge clk) begin
        if (!rst && !wr_n) wr_low <= wr_low + 1;
        if (!rst && !wr_n && !txe_n) begin
            tx_log[tx_cnt[5:0]] <= ftdi_data;
            tx_cnt <= tx_cnt + 1;
        end
    end

    // sof and bus-contention monitors.
    int         sof_cnt = 0;
    logic [7:0] sof_data = 8'h00;
    int         conflicts = 0;
    logic       oe_prev_low = 1'b0;
    always @(negedge clk) begin
        if (!rst && hif.sof) begin
            sof_cnt  <= sof_cnt + 1;
            sof_data <= hif.in_fifo_data;
        end
        if (!rst && dut.data_oe && (!oe_n || oe_prev_low)) conflicts <= conflicts + 1;
        oe_prev_low <= !oe_n;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        hif.out_fifo_data = b;
        hif.out_fifo_wr   = 1'b1;
        @(negedge clk);
        hif.out_fifo_wr   = 1'b0;
    endtask

    task automatic chip_add(input logic [7:0] b);
        chip_mem[chip_len[5:0]] = b;
        chip_len = chip_len + 1;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        int w = 0;
        while (hif.in_fifo_empty && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_avail"}, hif.in_fifo_empty, 1'b0);
        check_eq(tag, hif.in_fifo_data, exp);
        hif.in_fifo_rd = 1'b1;
        @(negedge clk);
        hif.in_fifo_rd = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached, expected test completion");
        $fatal(1);
    end

    initial begin
        int base, tbase, wbase, sbase, w;
        logic [7:0] wr_bytes [5];
        wr_bytes[0] = 8'hDC; wr_bytes[1] = 8'h0F; wr_bytes[2] = 8'h00;
        wr_bytes[3] = 8'h00; wr_bytes[4] = 8'h00;

        rst = 1'b1;
        txe_n = 1'b1;
        suspend_n = 1'b1;
        hif.in_fifo_rst = 1'b0;
        hif.in_fifo_rd = 1'b0;
        hif.out_fifo_wr = 1'b0;
        hif.out_fifo_data = 8'h00;

        // Reset state.
        tick(2);
        check_eq("rst_strobes", {rd_n, wr_n, oe_n, siwu}, 4'b1111);
        check_eq("rst_bus_z", dut.data_oe, 1'b0);
        check_eq("rst_empty", hif.in_fifo_empty, 1'b1);
        check_eq("rst_full", hif.out_fifo_full, 1'b0);
        check_eq("rst_sof", hif.sof, 1'b0);
        check_eq("rst_data", hif.in_fifo_data, 8'h00);
        rst = 1'b0;
        hif.in_fifo_rd = 1'b1;
        tick(1);
        hif.in_fifo_rd = 1'b0;
        check_eq("pop_empty_ignored", hif.in_fifo_empty, 1'b1);

        // Read burst of five bytes; OE# leads RD# by one cycle.
        base = chip_idx;
        sbase = sof_cnt;
        chip_add(8'hCD); chip_add(8'h10); chip_add(8'h00); chip_add(8'h00); chip_add(8'h01);
        w = 0;
        while (oe_n && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("oe_fall", oe_n, 1'b0);
        check_eq("rd_high_in_oe", rd_n, 1'b1);
        tick(1);
        check_eq("rd_fall", rd_n, 1'b0);
        check_eq("oe_held", oe_n, 1'b0);
        tick(15);
        check_eq("rd_burst_len", chip_idx - base, 5);
        check_eq("rd_sof_cnt", sof_cnt - sbase, 1);
        check_eq("rd_sof_data", sof_data, 8'hCD);
        pop_rx("rd0", 8'hCD); pop_rx("rd1", 8'h10); pop_rx("rd2", 8'h00);
        pop_rx("rd3", 8'h00); pop_rx("rd4", 8'h01);
        check_eq("rd_drained", hif.in_fifo_empty, 1'b1);

        // Write stream with TXE# low throughout.
        tbase = tx_cnt;
        wbase = wr_low;
        txe_n = 1'b0;
        for (int i = 0; i < 5; i++) push_tx(wr_bytes[i]);
        tick(20);
        check_eq("wr_low_cycles", wr_low - wbase, 5);
        check_eq("wr_count", tx_cnt - tbase, 5);
        for (int i = 0; i < 5; i++) check_eq("wr_byte", tx_log[tbase + i], wr_bytes[i]);

        // TXE# pause mid-stream loses nothing.
        tbase = tx_cnt;
        txe_n = 1'b1;
        for (int i = 0; i < 6; i++) push_tx(8'hA1 + 8'(i));
        txe_n = 1'b0;
        tick(3);
        txe_n = 1'b1;
        tick(3);
        txe_n = 1'b0;
        tick(20);
        check_eq("pause_count", tx_cnt - tbase, 6);
        for (int i = 0; i < 6; i++) check_eq("pause_byte", tx_log[tbase + i], 8'hA1 + 8'(i));

        // TX full: ninth push is dropped.
        tbase = tx_cnt;
        txe_n = 1'b1;
        for (int i = 0; i < 9; i++) push_tx(8'hB0 + 8'(i));
        check_eq("tx_full", hif.out_fifo_full, 1'b1);
        txe_n = 1'b0;
        tick(20);
        check_eq("full_count", tx_cnt - tbase, 8);
        check_eq("full_first", tx_log[tbase], 8'hB0);
        check_eq("full_last", tx_log[tbase + 7], 8'hB7);
        check_eq("tx_not_full", hif.out_fifo_full, 1'b0);

        // Read pre-empts an ongoing write.
        tbase = tx_cnt;
        txe_n = 1'b1;
        for (int i = 0; i < 4; i++) push_tx(8'hC0 + 8'(i));
        txe_n = 1'b0;
        w = 0;
        while (wr_n && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("cont_wr_start", wr_n, 1'b0);
        chip_add(8'hE1); chip_add(8'hE2);
        tick(2);
        check_eq("cont_preempt_cnt", tx_cnt - tbase, 1);
        check_eq("cont_rd_oe", oe_n, 1'b0);
        tick(25);
        check_eq("cont_wr_count", tx_cnt - tbase, 4);
        for (int i = 0; i < 4; i++) check_eq("cont_wr_byte", tx_log[tbase + i], 8'hC0 + 8'(i));
        pop_rx("cont_rd0", 8'hE1);
        pop_rx("cont_rd1", 8'hE2);

        // RX back-pressure with an 8-deep FIFO and margin 4.
        base = chip_idx;
        for (int i = 0; i < 20; i++) chip_add(8'hD0 + 8'(i));
        tick(30);
        check_eq("bp_accepted", chip_idx - base, 6);
        check_eq("bp_rd_high", rd_n, 1'b1);
        check_eq("bp_oe_high", oe_n, 1'b1);
        for (int i = 0; i < 20; i++) pop_rx("bp_byte", 8'hD0 + 8'(i));
        check_eq("bp_all_read", chip_idx - base, 20);
        check_eq("bp_drained", hif.in_fifo_empty, 1'b1);

        // RX flush, then a new frame raises sof again.
        chip_add(8'hF1); chip_add(8'hF2); chip_add(8'hF3);
        tick(15);
        check_eq("flush_pre_nonempty", hif.in_fifo_empty, 1'b0);
        hif.in_fifo_rst = 1'b1;
        tick(1);
        hif.in_fifo_rst = 1'b0;
        check_eq("flush_empty", hif.in_fifo_empty, 1'b1);
        check_eq("flush_sof", hif.sof, 1'b0);
        sbase = sof_cnt;
        chip_add(8'hCD);
        tick(15);
        check_eq("flush_sof_cnt", sof_cnt - sbase, 1);
        check_eq("flush_sof_data", sof_data, 8'hCD);
        pop_rx("flush_rd", 8'hCD);

        // Suspend holds all strobes high despite pending work.
        tbase = tx_cnt;
        suspend_n = 1'b0;
        chip_add(8'h77);
        push_tx(8'h5A);
        for (int i = 0; i < 6; i++) begin
            check_eq("susp_strobes", {rd_n, wr_n, oe_n}, 3'b111);
            tick(1);
        end
        suspend_n = 1'b1;
        tick(20);
        pop_rx("susp_rd", 8'h77);
        check_eq("susp_wr_count", tx_cnt - tbase, 1);
        check_eq("susp_wr_byte", tx_log[tbase], 8'h5A);

        // Reset mid-burst.
        for (int i = 0; i < 4; i++) chip_add(8'h31 + 8'(i));
        w = 0;
        while (rd_n && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("midrst_rd_active", rd_n, 1'b0);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_strobes", {rd_n, wr_n, oe_n}, 3'b111);
        check_eq("midrst_empty", hif.in_fifo_empty, 1'b1);
        check_eq("midrst_bus_z", dut.data_oe, 1'b0);
        rst = 1'b0;
        tick(2);

        check_eq("bus_conflict", conflicts, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
